vending_ctrl: RTL and testbench

Parametrised multi-product vending controller; next generation of the single-product coffee vending FSM.
- Accumulates coin credit and lets the customer pick one of NUM_PROD products with run-time prices.
- Drives a dispenser over a req/ack handshake and returns change.
- Counts completed vends and refunds credit on cancel or on dispenser timeout.
- Sits between the coin acceptor/keypad front end and the dispenser mechanics.

---
 rtl/vending_pkg.sv | 27 ++
 rtl/vend_timer.sv | 29 ++
 rtl/vending_ctrl.sv | 174 +++++++++++++++++
 tb/tb_vending_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and coin decoding for the multi-product vending controller.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    localparam logic [1:0] COIN_5  = 2'b00;
    localparam logic [1:0] COIN_10 = 2'b01;
    localparam logic [1:0] COIN_25 = 2'b10;
    localparam logic [1:0] COIN_50 = 2'b11;

    localparam int unsigned COIN_VAL_W = 6;

    // Credit units for a coin acceptor code; callers widen to their credit width.
    function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return 6'd5;
            COIN_10: return 6'd10;
            COIN_25: return 6'd25;
            default: return 6'd50;
        endcase
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Dispense watchdog: counts cycles while enabled, flags the last allowed cycle.
module vend_timer
    import vending_pkg::*;
#(
    parameter int unsigned DISP_TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned TW = $clog2(DISP_TIMEOUT + 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != TW'(DISP_TIMEOUT))) begin
            cnt <= cnt + TW'(1);
        end
    end

    // High on the DISP_TIMEOUT-th enabled cycle so the FSM acts on that edge.
    assign expired_c = enable && (cnt == TW'(DISP_TIMEOUT - 1));

endmodule

// File: rtl/vending_ctrl.sv
// Multi-product vending controller: coin credit, product selection, dispenser handshake and change.
module vending_ctrl
    import vending_pkg::*;
#(
    parameter int unsigned CREDIT_W     = 8,
    parameter int unsigned NUM_PROD     = 4,
    parameter int unsigned MAX_CREDIT   = 255,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DISP_TIMEOUT = 1000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            coin_valid,
    input  logic [1:0]                      coin_code,
    input  logic                            sel_valid,
    input  logic [$clog2(NUM_PROD)-1:0]     sel_id,
    input  logic [NUM_PROD*CREDIT_W-1:0]    price_flat,
    input  logic                            cancel,
    output logic                            disp_req,
    output logic [$clog2(NUM_PROD)-1:0]     disp_id,
    input  logic                            disp_ack,
    output logic                            change_valid,
    output logic [CREDIT_W-1:0]             change_amt,
    output logic [CREDIT_W-1:0]             credit,
    output logic                            coin_reject,
    output logic                            err_insuff,
    output logic                            disp_fault,
    output logic                            busy,
    output logic [CNT_W-1:0]                vend_count
);

    localparam int unsigned SEL_W = $clog2(NUM_PROD);
    localparam int unsigned SUM_W = CREDIT_W + 1;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_d, change_amt_d, base, price_sel, price_disp;
    logic [SUM_W-1:0]    coin_ext, coin_sum;
    logic [SEL_W-1:0]    disp_id_d;
    logic [CNT_W-1:0]    vend_count_d;
    logic                sel_ok, expired_c;
    logic                change_valid_d, coin_reject_d, err_insuff_d, disp_fault_d;

    vend_timer #(.DISP_TIMEOUT(DISP_TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_q != VEND),
        .enable    (state_q == VEND),
        .expired_c (expired_c)
    );

    // Price lookup; an index past NUM_PROD leaves sel_ok low.
    always_comb begin
        price_sel  = '0;
        price_disp = '0;
        sel_ok     = 1'b0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (SEL_W'(i) == sel_id) begin
                sel_ok    = 1'b1;
                price_sel = price_flat[i*CREDIT_W +: CREDIT_W];
            end
            if (SEL_W'(i) == disp_id) begin
                price_disp = price_flat[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    assign coin_ext = SUM_W'(coin_value(coin_code));

    always_comb begin
        state_d        = state_q;
        credit_d       = credit;
        disp_id_d      = disp_id;
        vend_count_d   = vend_count;
        change_valid_d = 1'b0;
        change_amt_d   = '0;
        coin_reject_d  = 1'b0;
        err_insuff_d   = 1'b0;
        disp_fault_d   = 1'b0;
        base           = credit;
        coin_sum       = '0;

        case (state_q)
            IDLE: begin
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    if (credit != '0) begin
                        change_valid_d = 1'b1;
                        change_amt_d   = credit;
                        credit_d       = '0;
                        state_d        = CHANGE;
                    end
                end else begin
                    if (sel_valid) begin
                        if (sel_ok && (credit >= price_sel)) begin
                            base      = credit - price_sel;
                            disp_id_d = sel_id;
                            state_d   = VEND;
                        end else begin
                            err_insuff_d = 1'b1;
                        end
                    end
                    credit_d = base;
                    // A same-cycle coin lands on whatever the selection left behind.
                    if (coin_valid) begin
                        coin_sum = {1'b0, base} + coin_ext;
                        if (coin_sum <= SUM_W'(MAX_CREDIT)) begin
                            credit_d = coin_sum[CREDIT_W-1:0];
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                end
            end
            VEND: begin
                coin_reject_d = coin_valid;
                if (disp_ack) begin
                    vend_count_d = (&vend_count) ? vend_count : vend_count + CNT_W'(1);
                    if (credit != '0) begin
                        change_valid_d = 1'b1;
                        change_amt_d   = credit;
                        credit_d       = '0;
                        state_d        = CHANGE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (expired_c) begin
                    disp_fault_d   = 1'b1;
                    change_valid_d = 1'b1;
                    change_amt_d   = credit + price_disp;
                    credit_d       = '0;
                    state_d        = CHANGE;
                end
            end
            CHANGE: begin
                coin_reject_d = coin_valid;
                credit_d      = '0;
                state_d       = IDLE;
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            credit       <= '0;
            disp_id      <= '0;
            vend_count   <= '0;
            disp_req     <= 1'b0;
            busy         <= 1'b0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            coin_reject  <= 1'b0;
            err_insuff   <= 1'b0;
            disp_fault   <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit       <= credit_d;
            disp_id      <= disp_id_d;
            vend_count   <= vend_count_d;
            disp_req     <= (state_d == VEND);
            busy         <= (state_d != IDLE);
            change_valid <= change_valid_d;
            change_amt   <= change_amt_d;
            coin_reject  <= coin_reject_d;
            err_insuff   <= err_insuff_d;
            disp_fault   <= disp_fault_d;
        end
    end

endmodule

// File: tb/tb_vending_ctrl.sv
// Bench for vending_ctrl: directed scenarios then random traffic against a transaction-level model.
module tb_vending_ctrl;

    localparam int TIMEOUT  = 8;
    localparam int CNT_MAX  = 3;
    localparam int MAXC     = 255;

    logic       clk, reset, coin_valid, sel_valid, cancel, disp_ack;
    logic [1:0] coin_code, sel_id, disp_id;
    logic [7:0] prices [4];
    logic [31:0] price_flat;
    logic       disp_req, change_valid, coin_reject, err_insuff, disp_fault, busy;
    logic [7:0] change_amt, credit;
    logic [1:0] vend_count;

    int checks = 0;
    int errors = 0;
    int cval [4] = '{5, 10, 25, 50};

    // Model: mode 0 = waiting for customer, 1 = dispensing, 2 = paying out
    int m_credit, m_count, m_mode, m_t, m_id;
    int e_cv, e_camt, e_rej, e_ins, e_flt, e_req, e_busy;

    assign price_flat = {prices[3], prices[2], prices[1], prices[0]};

    vending_ctrl #(
        .CREDIT_W(8), .NUM_PROD(4), .MAX_CREDIT(MAXC), .CNT_W(2), .DISP_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_code(coin_code),
        .sel_valid(sel_valid), .sel_id(sel_id), .price_flat(price_flat), .cancel(cancel),
        .disp_req(disp_req), .disp_id(disp_id), .disp_ack(disp_ack),
        .change_valid(change_valid), .change_amt(change_amt), .credit(credit),
        .coin_reject(coin_reject), .err_insuff(err_insuff), .disp_fault(disp_fault),
        .busy(busy), .vend_count(vend_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit cv, input int cc, input bit sv,
                         input int sid, input bit can, input bit ack);
        int rem;
        e_cv = 0; e_camt = 0; e_rej = 0; e_ins = 0; e_flt = 0;
        if (r) begin
            m_credit = 0; m_count = 0; m_mode = 0; m_t = 0; m_id = 0;
        end else if (m_mode == 0) begin
            if (can) begin
                e_rej = cv;
                if (m_credit > 0) begin
                    e_cv = 1; e_camt = m_credit; m_credit = 0; m_mode = 2;
                end
            end else begin
                rem = m_credit;
                if (sv) begin
                    if (sid < 4 && m_credit >= int'(prices[sid])) begin
                        rem = m_credit - int'(prices[sid]); m_id = sid; m_mode = 1; m_t = 0;
                    end else e_ins = 1;
                end
                if (cv) begin
                    if (rem + cval[cc] <= MAXC) rem += cval[cc];
                    else e_rej = 1;
                end
                m_credit = rem;
            end
        end else if (m_mode == 1) begin
            m_t++;
            e_rej = cv;
            if (ack) begin
                if (m_count < CNT_MAX) m_count++;
                if (m_credit > 0) begin
                    e_cv = 1; e_camt = m_credit; m_credit = 0; m_mode = 2;
                end else m_mode = 0;
            end else if (m_t == TIMEOUT) begin
                e_flt = 1; e_cv = 1; e_camt = m_credit + int'(prices[m_id]);
                m_credit = 0; m_mode = 2;
            end
        end else begin
            e_rej = cv;
            m_mode = 0;
        end
        e_req  = (m_mode == 1) ? 1 : 0;
        e_busy = (m_mode != 0) ? 1 : 0;
    endtask

    task automatic step(input bit r, input bit cv, input int cc, input bit sv,
                        input int sid, input bit can, input bit ack);
        @(negedge clk);
        reset = r; coin_valid = cv; coin_code = 2'(cc); sel_valid = sv;
        sel_id = 2'(sid); cancel = can; disp_ack = ack;
        model(r, cv, cc, sv, sid, can, ack);
        @(posedge clk);
        #1;
        chk("credit", 32'(credit), 32'(m_credit));
        chk("vend_count", 32'(vend_count), 32'(m_count));
        chk("disp_req", 32'(disp_req), 32'(e_req));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("change_valid", 32'(change_valid), 32'(e_cv));
        chk("change_amt", 32'(change_amt), 32'(e_camt));
        chk("coin_reject", 32'(coin_reject), 32'(e_rej));
        chk("err_insuff", 32'(err_insuff), 32'(e_ins));
        chk("disp_fault", 32'(disp_fault), 32'(e_flt));
        if (r || e_req == 1) chk("disp_id", 32'(disp_id), 32'(m_id));
    endtask

    task automatic idle();            step(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic coin(input int c); step(0, 1, c, 0, 0, 0, 0); endtask
    task automatic sel(input int s);  step(0, 0, 0, 1, s, 0, 0); endtask
    task automatic ack();             step(0, 0, 0, 0, 0, 0, 1); endtask
    task automatic cancel_req();      step(0, 0, 0, 0, 0, 1, 0); endtask

    initial begin
        reset = 1'b1; coin_valid = 1'b0; coin_code = 2'd0; sel_valid = 1'b0;
        sel_id = 2'd0; cancel = 1'b0; disp_ack = 1'b0;
        prices[0] = 8'd40; prices[1] = 8'd25; prices[2] = 8'd30; prices[3] = 8'd15;

        // 1: basic vend with change
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_credit", 32'(credit), 32'd0);
        coin(1); coin(2);
        chk("t1_credit35", 32'(credit), 32'd35);
        sel(2);
        chk("t1_req", 32'(disp_req), 32'd1);
        chk("t1_id", 32'(disp_id), 32'd2);
        chk("t1_credit5", 32'(credit), 32'd5);
        ack();
        chk("t1_change", 32'(change_amt), 32'd5);
        idle();

        // 2: overflow rejection near MAX_CREDIT
        coin(3); coin(3); coin(3); coin(3); coin(2); coin(1); coin(0);
        coin(3);
        chk("t2_reject", 32'(coin_reject), 32'd1);
        chk("t2_credit240", 32'(credit), 32'd240);
        coin(1);
        chk("t2_credit250", 32'(credit), 32'd250);
        cancel_req(); idle();

        // 3: insufficient credit then cancel
        coin(1); coin(1);
        sel(1);
        chk("t3_insuff", 32'(err_insuff), 32'd1);
        cancel_req();
        chk("t3_refund", 32'(change_amt), 32'd20);
        idle();

        // 4: dispenser timeout, then ack on the last allowed cycle
        coin(3); sel(0);
        for (int i = 0; i < TIMEOUT - 1; i++) idle();
        chk("t4_req_held", 32'(disp_req), 32'd1);
        idle();
        chk("t4_fault", 32'(disp_fault), 32'd1);
        chk("t4_refund50", 32'(change_amt), 32'd50);
        idle();
        coin(3); sel(0);
        for (int i = 0; i < TIMEOUT - 1; i++) idle();
        ack();
        chk("t4_ack_wins", 32'(disp_fault), 32'd0);
        chk("t4_change10", 32'(change_amt), 32'd10);
        idle();

        // 5: same-cycle priority
        coin(1); coin(0);
        step(0, 1, 2, 0, 0, 1, 0);
        chk("t5_cancel_coin", 32'(change_amt), 32'd15);
        idle();
        coin(1); coin(0);
        step(0, 1, 0, 1, 3, 0, 0);
        chk("t5_sel_coin", 32'(credit), 32'd5);
        ack(); idle();

        // 6: coin during vend, reset mid-vend, counter saturation
        coin(3); sel(0);
        coin(2);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t6_rst_req", 32'(disp_req), 32'd0);
        prices[1] = 8'd0;
        for (int i = 0; i < 4; i++) begin
            sel(1); ack();
        end
        chk("t6_saturate", 32'(vend_count), 32'd3);
        idle();

        // Random traffic
        for (int i = 0; i < 4; i++) prices[i] = 8'($urandom_range(0, 60));
        for (int n = 0; n < 800; n++) begin
            bit r;
            r = ($urandom_range(0, 99) == 0);
            if (r) for (int i = 0; i < 4; i++) prices[i] = 8'($urandom_range(0, 60));
            step(r, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
